fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Program-counter and fetch controller for the single-issue 8-register CPU. Owns the PC, issues read requests to instruction memory with a busywait handshake, latches the fetched 32-bit word for the instruction decoder, and advances the PC once per retired instruction. PC+4 is the default advance; a taken branch or jump redirects the PC to an 8-bit signed word offset. The block also freezes the PC while the data memory is busy.

## Interface
Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-low reset.
- INSTR_BUSYWAIT  in  1  instruction memory not ready; high while a requested read is pending.
- INSTR_RDATA  in  32  instruction word; valid on an edge where INSTR_READ=1 and INSTR_BUSYWAIT=0.
- DATA_BUSYWAIT  in  1  data memory stall; holds the current instruction in EXEC.
- BRANCH_TAKEN  in  1  from control: conditional branch resolved taken.
- JUMP  in  1  from control: unconditional jump.
- INSTR_READ  out  1  instruction memory read request.
- INSTR_ADDR  out  32  fetch address; always equals PC.
- PC  out  32  current program counter.
- INSTRUCTION  out  32  latched instruction word, driven to the decoder.
- INSTR_VALID  out  1  INSTRUCTION is live for the control and datapath.
- RETIRED  out  CNT_WIDTH  count of retired instructions.

## Operation
- States:
  - IDLE: reset hold.
  - FETCH: request outstanding.
  - EXEC: instruction presented to the decoder.
- IDLE:
  - INSTR_READ=0, INSTR_VALID=0.
  - Next edge with RESET=1 → FETCH.
- FETCH:
  - INSTR_READ=1.
  - INSTR_BUSYWAIT=1 → stay in FETCH, request held, PC stable.
  - INSTR_BUSYWAIT=0 → INSTRUCTION<=INSTR_RDATA, INSTR_VALID<=1, → EXEC.
- EXEC:
  - INSTR_READ=0, INSTR_VALID=1, INSTRUCTION held.
  - DATA_BUSYWAIT=1 → stay in EXEC. PC, INSTRUCTION and RETIRED are frozen, and BRANCH_TAKEN/JUMP are ignored.
  - DATA_BUSYWAIT=0 → PC<=next_pc, RETIRED<=RETIRED+1, INSTR_VALID<=0, → FETCH.
- next_pc:
  - Target = PC+4+{{22{OFF[7]}},OFF,2'b00}, with OFF=INSTRUCTION[23:16].
  - If JUMP or BRANCH_TAKEN: next_pc = target.
  - Otherwise: next_pc = PC+4.
  - JUMP and BRANCH_TAKEN both high behaves identically to either one alone.
- Arithmetic: 32-bit modulo. PC=32'hFFFFFFFC with no branch wraps to 0. OFF=8'h80 gives a displacement of -512 bytes from PC+4.
- RETIRED wraps from all-ones to 0 with no flag.
- Reset values, applied on any edge with RESET=0 from any state, with any pending request or stall abandoned:
  - PC=INSTR_ADDR=RESET_PC.
  - INSTR_READ=0, INSTR_VALID=0, INSTRUCTION=0, RETIRED=0.
  - State=IDLE.
- Inputs during IDLE are ignored. INSTR_BUSYWAIT outside FETCH is ignored.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- After reset release: first edge → FETCH. INSTR_READ goes high in the cycle after that edge.
- Zero-wait fetch costs 1 cycle in FETCH and 1 cycle in EXEC. Minimum issue interval is 2 cycles per instruction.
- Each cycle of INSTR_BUSYWAIT=1 in FETCH adds 1 cycle. Each cycle of DATA_BUSYWAIT=1 in EXEC adds 1 cycle.
- BRANCH_TAKEN/JUMP are sampled only on the edge leaving EXEC. The new PC appears on INSTR_ADDR in the same cycle INSTR_READ re-asserts.
- INSTR_ADDR is stable for the entire FETCH residency.

## Test plan
- Reset, RESET_PC=0, INSTR_BUSYWAIT=0, no branches, 4 instructions → INSTR_ADDR sequence 0,4,8,12, each fetched 2 cycles apart; RETIRED=4; INSTR_VALID high exactly one cycle per instruction.
- Fetch at PC=8 with INSTR_BUSYWAIT high for 3 cycles → INSTR_READ held 4 cycles with INSTR_ADDR=8; INSTRUCTION captured on the first low-busywait edge.
- PC=0x20, INSTRUCTION[23:16]=8'hFE, BRANCH_TAKEN=1 → next INSTR_ADDR=0x1C. Repeat with OFF=8'h03 and JUMP=1 → 0x30.
- EXEC with DATA_BUSYWAIT high 5 cycles and BRANCH_TAKEN toggling during the stall; BRANCH_TAKEN=0 on the release edge → PC frozen for 5 cycles, RETIRED unchanged until release, then PC+4.
- RESET driven low mid-FETCH while INSTR_BUSYWAIT=1 → next cycle all outputs at reset values and state IDLE; fetch restarts from RESET_PC after release.
- PC=0xFFFFFFFC, no branch → PC wraps to 0. RETIRED preloaded via 65535 retirements (CNT_WIDTH=16) → wraps to 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : PC owner and fetch/exec sequencer with busywait handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 INSTR_BUSYWAIT,
    input  logic [31:0]          INSTR_RDATA,
    input  logic                 DATA_BUSYWAIT,
    input  logic                 BRANCH_TAKEN,
    input  logic                 JUMP,
    output logic                 INSTR_READ,
    output logic [31:0]          INSTR_ADDR,
    output logic [31:0]          PC,
    output logic [31:0]          INSTRUCTION,
    output logic                 INSTR_VALID,
    output logic [CNT_WIDTH-1:0] RETIRED
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    localparam logic [31:0]          c_pc_step = 32'd4;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    state_t               r_state;
    logic [31:0]          r_pc;
    logic [31:0]          r_instr;
    logic                 r_valid;
    logic [CNT_WIDTH-1:0] r_retired;

    logic [31:0]          w_seq_pc;
    logic [31:0]          w_disp;
    logic [31:0]          w_target;
    logic [31:0]          w_next_pc;

    // Branch displacement is a signed word offset taken from the latched
    // instruction, so only the held INSTRUCTION feeds the target adder.
    always_comb begin
        w_seq_pc  = r_pc + c_pc_step;
        w_disp    = {{22{r_instr[23]}}, r_instr[23:16], 2'b00};
        w_target  = w_seq_pc + w_disp;
        w_next_pc = (JUMP || BRANCH_TAKEN) ? w_target : w_seq_pc;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state   <= ST_IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= '0;
            r_valid   <= 1'b0;
            r_retired <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (!INSTR_BUSYWAIT) begin
                        r_instr <= INSTR_RDATA;
                        r_valid <= 1'b1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // A data-memory stall freezes everything, including the
                    // redirect decision, until the stall drops.
                    if (!DATA_BUSYWAIT) begin
                        r_pc      <= w_next_pc;
                        r_retired <= r_retired + c_cnt_one;
                        r_valid   <= 1'b0;
                        r_state   <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign INSTR_READ  = (r_state == ST_FETCH);
    assign INSTR_ADDR  = r_pc;
    assign PC          = r_pc;
    assign INSTRUCTION = r_instr;
    assign INSTR_VALID = r_valid;
    assign RETIRED     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Directed self-checking bench for fetch_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int          CW       = 8;
    localparam logic [31:0] RST_PC   = 32'd0;

    logic          CLK;
    logic          RESET;
    logic          INSTR_BUSYWAIT;
    logic [31:0]   INSTR_RDATA;
    logic          DATA_BUSYWAIT;
    logic          BRANCH_TAKEN;
    logic          JUMP;
    logic          INSTR_READ;
    logic [31:0]   INSTR_ADDR;
    logic [31:0]   PC;
    logic [31:0]   INSTRUCTION;
    logic          INSTR_VALID;
    logic [CW-1:0] RETIRED;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   exp_pc;
    logic [CW-1:0] exp_ret;

    fetch_sequencer #(
        .RESET_PC  (RST_PC),
        .CNT_WIDTH (CW)
    ) u_dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .INSTR_BUSYWAIT (INSTR_BUSYWAIT),
        .INSTR_RDATA    (INSTR_RDATA),
        .DATA_BUSYWAIT  (DATA_BUSYWAIT),
        .BRANCH_TAKEN   (BRANCH_TAKEN),
        .JUMP           (JUMP),
        .INSTR_READ     (INSTR_READ),
        .INSTR_ADDR     (INSTR_ADDR),
        .PC             (PC),
        .INSTRUCTION    (INSTRUCTION),
        .INSTR_VALID    (INSTR_VALID),
        .RETIRED        (RETIRED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mkw(input logic [7:0] off, input logic [15:0] tag);
        return {8'hC3, off, tag};
    endfunction

    // Entered #1 after an edge with the DUT in FETCH; leaves it there again.
    task automatic run_instr(input logic [31:0] word, input int ibw, input int dbw,
                             input logic br, input logic jp);
        logic [31:0] addr;
        addr = exp_pc;
        chk("fetch_read", {31'd0, INSTR_READ}, 32'd1);
        chk("fetch_addr", INSTR_ADDR, exp_pc);
        chk("fetch_valid", {31'd0, INSTR_VALID}, 32'd0);
        INSTR_RDATA = word;
        for (int i = 0; i < ibw; i++) begin
            INSTR_BUSYWAIT = 1'b1;
            tick();
            chk("ibw_read", {31'd0, INSTR_READ}, 32'd1);
            chk("ibw_addr", INSTR_ADDR, addr);
            chk("ibw_valid", {31'd0, INSTR_VALID}, 32'd0);
        end
        INSTR_BUSYWAIT = 1'b0;
        tick();
        chk("exec_valid", {31'd0, INSTR_VALID}, 32'd1);
        chk("exec_read", {31'd0, INSTR_READ}, 32'd0);
        chk("exec_instr", INSTRUCTION, word);
        INSTR_RDATA = ~word;
        for (int i = 0; i < dbw; i++) begin
            DATA_BUSYWAIT  = 1'b1;
            INSTR_BUSYWAIT = 1'b1;
            BRANCH_TAKEN   = (i % 2 == 0);
            JUMP           = (i % 3 == 1);
            tick();
            chk("stall_pc", PC, addr);
            chk("stall_ret", {24'd0, RETIRED}, {24'd0, exp_ret});
            chk("stall_valid", {31'd0, INSTR_VALID}, 32'd1);
            chk("stall_instr", INSTRUCTION, word);
        end
        DATA_BUSYWAIT  = 1'b0;
        INSTR_BUSYWAIT = 1'b0;
        BRANCH_TAKEN   = br;
        JUMP           = jp;
        tick();
        BRANCH_TAKEN = 1'b0;
        JUMP         = 1'b0;
        exp_pc  = exp_pc + 32'd4 + ((br || jp) ? {{22{word[23]}}, word[23:16], 2'b00} : 32'd0);
        exp_ret = exp_ret + CW'(1);
        chk("next_pc", PC, exp_pc);
        chk("next_addr", INSTR_ADDR, exp_pc);
        chk("next_ret", {24'd0, RETIRED}, {24'd0, exp_ret});
        chk("next_valid", {31'd0, INSTR_VALID}, 32'd0);
        chk("next_read", {31'd0, INSTR_READ}, 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"}, PC, RST_PC);
        chk({tag, "_addr"}, INSTR_ADDR, RST_PC);
        chk({tag, "_read"}, {31'd0, INSTR_READ}, 32'd0);
        chk({tag, "_valid"}, {31'd0, INSTR_VALID}, 32'd0);
        chk({tag, "_instr"}, INSTRUCTION, 32'd0);
        chk({tag, "_ret"}, {24'd0, RETIRED}, 32'd0);
    endtask

    initial begin
        RESET          = 1'b0;
        INSTR_BUSYWAIT = 1'b0;
        INSTR_RDATA    = 32'd0;
        DATA_BUSYWAIT  = 1'b0;
        BRANCH_TAKEN   = 1'b0;
        JUMP           = 1'b0;
        exp_pc         = RST_PC;
        exp_ret        = '0;

        tick();
        tick();
        chk_reset_state("rst");
        RESET = 1'b1;
        #1;
        chk("idle_read", {31'd0, INSTR_READ}, 32'd0);
        tick();
        chk("first_fetch_read", {31'd0, INSTR_READ}, 32'd1);

        // Sequential fetch 0,4,8,12; the fetch at 8 waits 3 cycles.
        run_instr(mkw(8'h00, 16'h0001), 0, 0, 1'b0, 1'b0);
        run_instr(mkw(8'h00, 16'h0002), 0, 0, 1'b0, 1'b0);
        run_instr(mkw(8'h00, 16'h0003), 3, 0, 1'b0, 1'b0);
        run_instr(mkw(8'h00, 16'h0004), 0, 0, 1'b0, 1'b0);
        chk("seq_pc16", PC, 32'h10);
        chk("seq_ret4", {24'd0, RETIRED}, 32'd4);

        // Redirects: 0x10 -> 0x20, 0x20 -(-2)-> 0x1C, 0x1C -> 0x20, 0x20 -(+3)-> 0x30.
        run_instr(mkw(8'h03, 16'h0010), 0, 0, 1'b0, 1'b1);
        chk("jump_to_20", PC, 32'h20);
        run_instr(mkw(8'hFE, 16'h0011), 0, 0, 1'b1, 1'b0);
        chk("branch_to_1c", PC, 32'h1C);
        run_instr(mkw(8'h03, 16'h0012), 0, 0, 1'b0, 1'b0);
        run_instr(mkw(8'h03, 16'h0013), 0, 0, 1'b0, 1'b1);
        chk("jump_to_30", PC, 32'h30);
        run_instr(mkw(8'hFF, 16'h0014), 0, 0, 1'b1, 1'b1);
        chk("both_to_30", PC, 32'h30);

        // Data stall of 5 cycles with redirect inputs toggling; release not taken.
        run_instr(mkw(8'h40, 16'h0020), 0, 5, 1'b0, 1'b0);
        chk("stall_release_pc", PC, 32'h34);

        // Reset in the middle of a stalled fetch.
        INSTR_BUSYWAIT = 1'b1;
        tick();
        chk("midfetch_read", {31'd0, INSTR_READ}, 32'd1);
        RESET = 1'b0;
        tick();
        chk_reset_state("midrst");
        exp_pc  = RST_PC;
        exp_ret = '0;
        RESET = 1'b1;
        tick();
        INSTR_BUSYWAIT = 1'b0;

        // Wraparound: 0 -(-2)-> 0xFFFFFFFC -> 0, then OFF=0x80 gives -512 from PC+4.
        run_instr(mkw(8'hFE, 16'h0030), 0, 0, 1'b0, 1'b1);
        chk("to_fffffffc", PC, 32'hFFFF_FFFC);
        run_instr(mkw(8'h10, 16'h0031), 0, 0, 1'b0, 1'b0);
        chk("pc_wrap_0", PC, 32'h0);
        run_instr(mkw(8'h80, 16'h0032), 0, 0, 1'b1, 1'b0);
        chk("off_80", PC, 32'hFFFF_FE04);
        run_instr(mkw(8'h00, 16'h0033), 0, 0, 1'b0, 1'b0);

        // Retire until the counter rolls over to zero.
        for (int k = 4; k < (1 << CW); k++) begin
            run_instr(mkw(8'h00, 16'(k)), 0, 0, 1'b0, 1'b0);
        end
        chk("retired_wrap", {24'd0, RETIRED}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
